// File: rtl/instruction_memory_pl.sv
// Instruction memory with a registered fetch port and a program write port.
// After reset every word is overwritten with NOP_WORD before reads or writes are accepted.
module instruction_memory_pl #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rd_req,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_ready,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_instruction
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // state   | meaning
    // S_CLEAR | sweeping NOP_WORD through memory, ports ignored
    // S_RUN   | fetch and program ports active
    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clear_ptr;
    logic                  r_ready;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_instruction;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_clear_last;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_waddr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_bypass;

    assign w_clear_last = (r_clear_ptr == ADDR_WIDTH'(DEPTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (w_clear_last) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_CLEAR;
            r_clear_ptr <= '0;
            r_ready     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_RUN);
            if (r_state == S_CLEAR && !w_clear_last)
                r_clear_ptr <= r_clear_ptr + 1'b1;
        end
    end

    // Clear sweep owns the single write port until the FSM reaches RUN.
    always_comb begin
        w_mem_we    = i_wr_en;
        w_mem_waddr = i_wr_addr;
        w_mem_wdata = i_wr_data;
        if (r_state == S_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_clear_ptr;
            w_mem_wdata = NOP_WORD;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_mem_we)
            r_mem[w_mem_waddr] <= w_mem_wdata;
    end

    assign w_rd_word = r_mem[i_rd_addr];
    assign w_bypass  = i_wr_en && (i_wr_addr == i_rd_addr);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_valid    <= 1'b0;
            r_instruction <= NOP_WORD;
        end else if (r_state == S_CLEAR || i_flush) begin
            r_rd_valid    <= 1'b0;
            r_instruction <= NOP_WORD;
        end else if (!i_stall) begin
            r_rd_valid <= i_rd_req;
            if (i_rd_req)
                r_instruction <= w_bypass ? i_wr_data : w_rd_word;
        end
    end

    assign o_ready       = r_ready;
    assign o_rd_valid    = r_rd_valid;
    assign o_instruction = r_instruction;

endmodule

// File: tb/tb_instruction_memory_pl.sv
// Randomized and directed bench for instruction_memory_pl against a word-array reference model.
module tb_instruction_memory_pl;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 64;
    localparam logic [DW-1:0] NOP = 16'h0000;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_rd_req = 1'b0;
    logic [AW-1:0] i_rd_addr = '0;
    logic          i_stall = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_wr_en = 1'b0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [DW-1:0] i_wr_data = '0;
    logic          o_ready;
    logic          o_rd_valid;
    logic [DW-1:0] o_instruction;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_mem [DEPTH];
    int            m_clear_cnt;
    logic          m_ready;
    logic          m_valid;
    logic [DW-1:0] m_instr;

    instruction_memory_pl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NOP_WORD(NOP)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rd_req     (i_rd_req),
        .i_rd_addr    (i_rd_addr),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .i_wr_en      (i_wr_en),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .o_ready      (o_ready),
        .o_rd_valid   (o_rd_valid),
        .o_instruction(o_instruction)
    );

    always #5 i_clk = ~i_clk;

    // Reference: first DEPTH edges after reset are the clear; afterwards a write
    // lands before the read is looked up, which yields write-through naturally.
    task automatic model_edge();
        if (m_clear_cnt < DEPTH) begin
            m_clear_cnt++;
            m_valid = 1'b0;
            m_instr = NOP;
        end else begin
            if (i_wr_en) m_mem[i_wr_addr] = i_wr_data;
            if (i_flush) begin
                m_valid = 1'b0;
                m_instr = NOP;
            end else if (!i_stall) begin
                m_valid = i_rd_req;
                if (i_rd_req) m_instr = m_mem[i_rd_addr];
            end
        end
        m_ready = (m_clear_cnt >= DEPTH);
    endtask

    task automatic step();
        @(posedge i_clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        i_rd_req = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        #1;
        foreach (m_mem[a]) m_mem[a] = NOP;
        m_clear_cnt = 0; m_ready = 1'b0; m_valid = 1'b0; m_instr = NOP;
        n_tests++;
        if ({o_ready, o_rd_valid, o_instruction} !== {1'b0, 1'b0, NOP}) begin
            n_fail++;
            $display("FAIL reset_immediate: got ready=%b valid=%b instr=%h, want 0 0 %h",
                     o_ready, o_rd_valid, o_instruction, NOP);
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    // Runs the clear with ports active, counting cycles until ready rises.
    task automatic test_clear(input string tag);
        int cycles = 0;
        i_rd_req = 1'b1; i_rd_addr = 6'd3;
        i_wr_en = 1'b1; i_wr_addr = 6'd3; i_wr_data = 16'hFFFF;
        while (!o_ready && cycles < 200) begin
            step();
            cycles++;
            n_tests++;
            if ({o_ready, o_rd_valid, o_instruction} !== {m_ready, m_valid, m_instr}) begin
                n_fail++;
                $display("FAIL %s_clear_cyc%0d: got ready=%b valid=%b instr=%h, want %b %b %h",
                         tag, cycles, o_ready, o_rd_valid, o_instruction, m_ready, m_valid, m_instr);
            end
        end
        n_tests++;
        if (cycles !== DEPTH) begin
            n_fail++;
            $display("FAIL %s_clear_len: got %0d cycles, want %0d", tag, cycles, DEPTH);
        end
        idle_inputs();
        i_rd_addr = 6'd3;
        i_rd_req = 1'b1;
        step();
        i_rd_req = 1'b0;
        n_tests++;
        if ({o_rd_valid, o_instruction} !== {1'b1, NOP}) begin
            n_fail++;
            $display("FAIL %s_addr3_after_clear: got valid=%b instr=%h, want 1 %h",
                     tag, o_rd_valid, o_instruction, NOP);
        end
    endtask

    task automatic test_reset();
        do_reset();
        test_clear("por");
    endtask

    task automatic test_read_write();
        idle_inputs();
        i_rd_req = 1'b1; i_rd_addr = 6'd5;
        step();
        n_tests++;
        if ({o_rd_valid, o_instruction} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL read_addr5: got valid=%b instr=%h, want 1 0000", o_rd_valid, o_instruction);
        end
        i_rd_req = 1'b0; i_wr_en = 1'b1; i_wr_addr = 6'd7; i_wr_data = 16'hA5C3;
        step();
        i_wr_en = 1'b0; i_rd_req = 1'b1; i_rd_addr = 6'd7;
        step();
        n_tests++;
        if ({o_rd_valid, o_instruction} !== {1'b1, 16'hA5C3}) begin
            n_fail++;
            $display("FAIL read_addr7: got valid=%b instr=%h, want 1 a5c3", o_rd_valid, o_instruction);
        end
        i_rd_req = 1'b0;
        step();
        n_tests++;
        if ({o_rd_valid, o_instruction} !== {1'b0, 16'hA5C3}) begin
            n_fail++;
            $display("FAIL drop_hold: got valid=%b instr=%h, want 0 a5c3", o_rd_valid, o_instruction);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        i_wr_en = 1'b1; i_wr_addr = 6'd9; i_wr_data = 16'h1234;
        i_rd_req = 1'b1; i_rd_addr = 6'd9;
        step();
        idle_inputs();
        n_tests++;
        if ({o_rd_valid, o_instruction} !== {1'b1, 16'h1234}) begin
            n_fail++;
            $display("FAIL bypass_addr9: got valid=%b instr=%h, want 1 1234", o_rd_valid, o_instruction);
        end
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        i_rd_req = 1'b1; i_rd_addr = 6'd7;
        step();
        i_stall = 1'b1; i_rd_addr = 6'd9;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if ({o_rd_valid, o_instruction} !== {1'b1, 16'hA5C3}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got valid=%b instr=%h, want 1 a5c3",
                         k, o_rd_valid, o_instruction);
            end
        end
        i_flush = 1'b1;
        step();
        n_tests++;
        if ({o_rd_valid, o_instruction} !== {1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL stall_flush: got valid=%b instr=%h, want 0 0000", o_rd_valid, o_instruction);
        end
        i_stall = 1'b0; i_flush = 1'b0; i_rd_addr = 6'd7;
        step();
        i_flush = 1'b1;
        step();
        idle_inputs();
        n_tests++;
        if ({o_rd_valid, o_instruction} !== {1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL flush_over_read: got valid=%b instr=%h, want 0 0000", o_rd_valid, o_instruction);
        end
    endtask

    task automatic test_random(input int n);
        for (int k = 0; k < n; k++) begin
            i_rd_req  = 1'($urandom);
            i_rd_addr = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            i_wr_en   = 1'($urandom);
            i_wr_addr = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            i_wr_data = 16'($urandom);
            i_stall   = ($urandom_range(0, 4) == 0);
            i_flush   = ($urandom_range(0, 7) == 0);
            step();
            n_tests++;
            if ({o_ready, o_rd_valid, o_instruction} !== {m_ready, m_valid, m_instr}) begin
                n_fail++;
                $display("FAIL random_%0d: got ready=%b valid=%b instr=%h, want %b %b %h",
                         k, o_ready, o_rd_valid, o_instruction, m_ready, m_valid, m_instr);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 30; k++) step();
        do_reset();
        test_clear("midclear");
        i_wr_en = 1'b1; i_wr_addr = 6'd7; i_wr_data = 16'hA5C3;
        step();
        idle_inputs();
        do_reset();
        test_clear("midrun");
        i_rd_req = 1'b1; i_rd_addr = 6'd7;
        step();
        idle_inputs();
        n_tests++;
        if ({o_rd_valid, o_instruction} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL addr7_after_reset: got valid=%b instr=%h, want 1 0000", o_rd_valid, o_instruction);
        end
    endtask

    initial begin
        test_reset();
        test_read_write();
        test_bypass();
        test_stall_flush();
        test_random(400);
        test_reset_mid();
        test_random(300);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
